rf_sequencer: RTL

//  Command-driven initiator for the RF register file: accepts one op per handshake
//  and drives O1Sel/O2Sel/FunSel/RSel/TSel/I, capturing O1/O2 as needed.

---
 rtl/rf_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rf_sequencer.sv
// rf_sequencer: command-driven initiator for the RF register file.
// Accepts one op per cmd handshake and drives the registered RF control word
// (O1Sel/O2Sel/FunSel/RSel/TSel/I), capturing O1/O2 for MOVE and READ.
module rf_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [2:0]          cmd_src,
  input  logic [2:0]          cmd_dst,
  input  logic [DATA_W-1:0]   cmd_imm,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic [2:0]          O1Sel,
  output logic [2:0]          O2Sel,
  output logic [1:0]          FunSel,
  output logic [3:0]          RSel,
  output logic [3:0]          TSel,
  output logic [DATA_W-1:0]   I,
  input  logic [DATA_W-1:0]   O1,
  input  logic [DATA_W-1:0]   O2,
  output logic [CNT_W-1:0]    cmd_count
);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpClr  = 3'b010;
  localparam logic [2:0] OpInc  = 3'b011;
  localparam logic [2:0] OpDec  = 3'b100;
  localparam logic [2:0] OpMove = 3'b101;
  localparam logic [2:0] OpRead = 3'b110;

  localparam logic [1:0] FunClr  = 2'b00;
  localparam logic [1:0] FunLoad = 2'b01;
  localparam logic [1:0] FunDec  = 2'b10;
  localparam logic [1:0] FunInc  = 2'b11;

  typedef enum logic [2:0] {StIdle, StExec, StRd, StWr, StRsp} state_e;

  state_e     state_q;
  logic [2:0] op_q;
  logic [2:0] dst_q;

  // Reg code idx 0..3 maps to enable bit 3..0 (R1/T1 is the MSB).
  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [1:0] fun_of(input logic [2:0] op);
    case (op)
      OpClr:   return FunClr;
      OpLoad:  return FunLoad;
      OpDec:   return FunDec;
      default: return FunInc;
    endcase
  endfunction

  assign cmd_ready = (state_q == StIdle);

  // Sequencer FSM; every RF control output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      dst_q     <= 3'b000;
      O1Sel     <= 3'b000;
      O2Sel     <= 3'b000;
      FunSel    <= FunClr;
      RSel      <= 4'b0000;
      TSel      <= 4'b0000;
      I         <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      cmd_count <= '0;
    end else begin
      // Enables are single-cycle pulses unless a write is being issued now.
      RSel <= 4'b0000;
      TSel <= 4'b0000;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_count <= cmd_count + CNT_W'(1);
            op_q      <= cmd_op;
            dst_q     <= cmd_dst;
            case (cmd_op)
              OpLoad, OpClr, OpInc, OpDec: begin
                FunSel <= fun_of(cmd_op);
                if (cmd_op == OpLoad) I <= cmd_imm;
                if (cmd_dst[2]) RSel <= reg_onehot(cmd_dst[1:0]);
                else            TSel <= reg_onehot(cmd_dst[1:0]);
                state_q <= StExec;
              end
              OpMove, OpRead: begin
                O1Sel   <= cmd_src;
                O2Sel   <= cmd_dst;
                state_q <= StRd;
              end
              default: ;  // NOP and undefined 111: counted, no RF activity
            endcase
          end
        end
        StExec: state_q <= StIdle;
        StRd: begin
          if (op_q == OpMove) begin
            I      <= O1;
            FunSel <= FunLoad;
            if (dst_q[2]) RSel <= reg_onehot(dst_q[1:0]);
            else          TSel <= reg_onehot(dst_q[1:0]);
            state_q <= StWr;
          end else begin
            rsp_data  <= {O1, O2};
            rsp_valid <= 1'b1;
            state_q   <= StRsp;
          end
        end
        StWr: state_q <= StIdle;
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
